// File: rtl/boot_loader_pkg.sv
// Shared constants for the boot loader: FSM state encodings and header size.
// Latency: n/a (constants only).
// Backpressure: n/a.
package boot_loader_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_LEN0 = 3'd0;  // waiting for count[7:0]
    localparam logic [2:0] ST_LEN1 = 3'd1;  // waiting for count[15:8]
    localparam logic [2:0] ST_DATA = 3'd2;  // receiving image bytes
    localparam logic [2:0] ST_CSUM = 3'd3;  // waiting for checksum byte
    localparam logic [2:0] ST_DONE = 3'd4;  // image loaded, core released
    localparam logic [2:0] ST_ERR  = 3'd5;  // load aborted, core held

    // Length header: little-endian word count
    localparam int HDR_BYTES = 2;

endpackage

// File: rtl/boot_loader_word_assembler.sv
// Packs accepted bytes LSB-first into 32-bit words and pulses when one is complete.
// Latency: word_vld/word_dat registered, 1 cycle after the 4th byte is accepted.
// Backpressure: none of its own; only advances on byte_vld, so gaps stall it losslessly.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (drops any partial word)
//   byte_vld, byte_dat  one byte accepted this cycle
//   byte_cnt            slot the next accepted byte fills (0..3)
//   word_vld, word_dat  one-cycle completion pulse and the assembled word (held)
module boot_loader_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic [1:0]  byte_cnt,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    // Holds bytes 0..2 of the word in progress; byte 3 goes straight to word_dat
    logic [23:0] shift_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= 2'd0;
            shift_reg <= 24'd0;
            word_vld  <= 1'b0;
            word_dat  <= 32'd0;
        end else begin
            word_vld <= 1'b0;
            if (byte_vld) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: shift_reg[7:0]   <= byte_dat;
                    2'd1: shift_reg[15:8]  <= byte_dat;
                    2'd2: shift_reg[23:16] <= byte_dat;
                    default: begin
                        word_vld <= 1'b1;
                        word_dat <= {byte_dat, shift_reg};
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: length-prefixed byte stream -> 32-bit words into instruction memory, then releases core reset.
// Latency: imem_we 1 cycle after the 4th byte of a word; done/core_rst change 1 cycle after DONE entry.
// Backpressure: rx_ready registered; high in LEN0/LEN1/DATA(/CSUM), low after reset, in DONE and ERR.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   rx_valid, rx_data, rx_ready       byte stream handshake
//   imem_we, imem_addr, imem_wdata    instruction memory write port (byte address)
//   core_rst                          held high until the image is loaded
//   done, error                       sticky load status
// Optional feature macro: BOOT_CHECKSUM_EN (trailing XOR checksum byte after the data).
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = HDR_BYTES * 8;

    // Where the FSM goes once all data words (possibly zero) have been received
`ifdef BOOT_CHECKSUM_EN
    localparam logic [2:0] ST_AFTER_DATA = ST_CSUM;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_DONE;
`endif

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [CNT_W-1:0]  word_count;
    logic [CNT_W-1:0]  word_idx;
    logic [CNT_W-1:0]  count_full;
    logic [ADDR_W-1:0] addr_ext;
    logic [1:0]        byte_cnt;
    logic              accept;
    logic              data_acc;
    logic              word_last_byte;
    logic              rx_ready_nxt;

    assign accept         = rx_valid & rx_ready;
    assign data_acc       = accept && (state == ST_DATA);
    assign word_last_byte = data_acc && (byte_cnt == 2'd3);
    // Count as it stands once the high byte arriving this cycle is included
    assign count_full     = {rx_data, word_count[7:0]};
    assign addr_ext       = ADDR_W'(word_idx);

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= 8'd0;
        end else if (data_acc) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LEN0: begin
                if (accept) state_nxt = ST_LEN1;
            end
            ST_LEN1: begin
                if (accept) begin
                    if (count_full == '0)
                        state_nxt = ST_AFTER_DATA;
                    else if (count_full > CNT_W'(IMEM_WORDS))
                        state_nxt = ST_ERR;
                    else
                        state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_last_byte && (word_idx == word_count - 1'b1))
                    state_nxt = ST_AFTER_DATA;
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) state_nxt = (rx_data == csum) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: state_nxt = ST_DONE;
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_ERR;
        endcase
    end

    // rx_ready is registered, so it is derived from the state being entered
    assign rx_ready_nxt = (state_nxt == ST_LEN0) || (state_nxt == ST_LEN1) ||
                          (state_nxt == ST_DATA) || (state_nxt == ST_CSUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LEN0;
            rx_ready   <= 1'b0;
            imem_addr  <= '0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            word_idx   <= '0;
        end else begin
            state    <= state_nxt;
            rx_ready <= rx_ready_nxt;
            // Status follows the state one cycle after it is entered
            core_rst <= (state != ST_DONE);
            done     <= (state == ST_DONE);
            error    <= (state == ST_ERR);

            if (accept && (state == ST_LEN0)) word_count[7:0]  <= rx_data;
            if (accept && (state == ST_LEN1)) word_count[15:8] <= rx_data;

            // Address is latched alongside the assembler's word register
            if (word_last_byte) begin
                imem_addr <= addr_ext << 2;
                word_idx  <= word_idx + 1'b1;
            end
        end
    end

    boot_loader_word_assembler u_word_assembler (
        .clk      (clk),
        .rst      (rst),
        .byte_vld (data_acc),
        .byte_dat (rx_data),
        .byte_cnt (byte_cnt),
        .word_vld (imem_we),
        .word_dat (imem_wdata)
    );

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: normal load, empty image, oversize, gapped
// stream, reset mid-load and (when built with BOOT_CHECKSUM_EN) checksum cases.
module tb_boot_loader;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];

    logic [7:0] img2 [0:9];

    boot_loader #(.IMEM_WORDS(64), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write strobe, sampled away from the active edge
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting posedge
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int cycles);
        rx_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        img2[0] = 8'h02; img2[1] = 8'h00;
        img2[2] = 8'h13; img2[3] = 8'h05; img2[4] = 8'h50; img2[5] = 8'h00;
        img2[6] = 8'h93; img2[7] = 8'h05; img2[8] = 8'hA0; img2[9] = 8'h00;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);

        // ---- reset state (first cycle after reset release) ----
        do_reset();
        check("rst_rx_ready",   {31'd0, rx_ready}, 32'd0);
        check("rst_imem_we",    {31'd0, imem_we},  32'd0);
        check("rst_imem_addr",  imem_addr,         32'd0);
        check("rst_imem_wdata", imem_wdata,        32'd0);
        check("rst_core_rst",   {31'd0, core_rst}, 32'd1);
        check("rst_done",       {31'd0, done},     32'd0);
        check("rst_error",      {31'd0, error},    32'd0);

        // ---- two-word image, valid held high ----
        wr_addr.delete(); wr_data.delete();
        for (int i = 0; i < 10; i++) send_byte(img2[i]);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h70);
`endif
        rx_valid = 1'b0;
        check("b2b_entry_core_rst", {31'd0, core_rst}, 32'd1);
        check("b2b_entry_done",     {31'd0, done},     32'd0);
        check("b2b_entry_rx_ready", {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        check("b2b_core_rst", {31'd0, core_rst}, 32'd0);
        check("b2b_done",     {31'd0, done},     32'd1);
        idle(4);
        check("b2b_nwr",   wr_addr.size(), 32'd2);
        check("b2b_addr0", wr_addr[0], 32'h0000_0000);
        check("b2b_data0", wr_data[0], 32'h0050_0513);
        check("b2b_addr1", wr_addr[1], 32'h0000_0004);
        check("b2b_data1", wr_data[1], 32'h00A0_0593);
        check("b2b_error", {31'd0, error}, 32'd0);

        // ---- empty image ----
        do_reset();
        wr_addr.delete(); wr_data.delete();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h00);
`endif
        rx_valid = 1'b0;
        check("cnt0_entry_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("cnt0_done",     {31'd0, done},     32'd1);
        check("cnt0_core_rst", {31'd0, core_rst}, 32'd0);
        idle(3);
        check("cnt0_nwr", wr_addr.size(), 32'd0);

        // ---- count exactly IMEM_WORDS is accepted ----
        do_reset();
        send_byte(8'h40);
        send_byte(8'h00);
        idle(2);
        check("max_error",    {31'd0, error},    32'd0);
        check("max_rx_ready", {31'd0, rx_ready}, 32'd1);

        // ---- oversize count IMEM_WORDS+1 ----
        do_reset();
        wr_addr.delete(); wr_data.delete();
        send_byte(8'h41);
        send_byte(8'h00);
        check("ovr_rx_ready", {31'd0, rx_ready}, 32'd0);
        rx_data = 8'hAA;
        repeat (8) @(negedge clk);  // valid still high, nothing may be taken
        rx_valid = 1'b0;
        check("ovr_error",    {31'd0, error},    32'd1);
        check("ovr_rx_ready2",{31'd0, rx_ready}, 32'd0);
        check("ovr_core_rst", {31'd0, core_rst}, 32'd1);
        check("ovr_done",     {31'd0, done},     32'd0);
        check("ovr_nwr",      wr_addr.size(),    32'd0);

        // ---- gapped valid ----
        do_reset();
        wr_addr.delete(); wr_data.delete();
        for (int i = 0; i < 10; i++) begin
            send_byte(img2[i]);
            idle(1);
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h70);
        idle(1);
`endif
        idle(3);
        check("gap_nwr",   wr_addr.size(), 32'd2);
        check("gap_addr0", wr_addr[0], 32'h0000_0000);
        check("gap_data0", wr_data[0], 32'h0050_0513);
        check("gap_addr1", wr_addr[1], 32'h0000_0004);
        check("gap_data1", wr_data[1], 32'h00A0_0593);
        check("gap_done",  {31'd0, done}, 32'd1);

        // ---- reset mid-load, after 2 bytes of the second word ----
        do_reset();
        wr_addr.delete(); wr_data.delete();
        for (int i = 0; i < 8; i++) send_byte(img2[i]);
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_core_rst", {31'd0, core_rst}, 32'd1);
        check("mid_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("mid_done",     {31'd0, done},     32'd0);
        rst = 1'b0;
        idle(3);
        check("mid_nwr",   wr_addr.size(), 32'd1);
        check("mid_data0", wr_data[0], 32'h0050_0513);
        wr_addr.delete(); wr_data.delete();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h22);
`endif
        idle(3);
        check("mid_reload_nwr",  wr_addr.size(), 32'd1);
        check("mid_reload_addr", wr_addr[0], 32'h0000_0000);
        check("mid_reload_data", wr_data[0], 32'hDEAD_BEEF);
        check("mid_reload_done", {31'd0, done},     32'd1);
        check("mid_reload_crst", {31'd0, core_rst}, 32'd0);

`ifdef BOOT_CHECKSUM_EN
        // ---- checksum mismatch: XOR of data bytes is 0x70, send 0x71 ----
        do_reset();
        wr_addr.delete(); wr_data.delete();
        for (int i = 0; i < 10; i++) send_byte(img2[i]);
        send_byte(8'h71);
        idle(3);
        check("csum_bad_nwr",      wr_addr.size(), 32'd2);
        check("csum_bad_error",    {31'd0, error},    32'd1);
        check("csum_bad_done",     {31'd0, done},     32'd0);
        check("csum_bad_core_rst", {31'd0, core_rst}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
